writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//   Final pipeline stage of the 8-bit core, directly downstream of memory_stage.
//   - Holds the MEM/WB pipeline register.
//   - Aligns in-flight control with the registered load data from memory_stage.
//   - Selects the writeback value and commits it to an internal 8x8 register
//     file, which has two read ports with write-through bypass.
//   - Exports a forwarding bus and a count of retired instructions.
// PARAMETERS
//   DATA_W      8    datapath / register width
//   REG_ADDR_W  3    register index width; register file has 2**REG_ADDR_W entries
//   CNT_W       16   retired-instruction counter width
// PORTS
//   clk            in   1           clock, rising edge
//   reset          in   1           asynchronous, active-high
//   stall          in   1           hold MEM/WB register; suppress commit
//   flush          in   1           kill the instruction being captured
//   m_valid        in   1           instruction present in MEM this cycle
//   m_reg_write    in   1           instruction writes rd
//   m_mem_to_reg   in   1           1: write load data; 0: write ALU result
//   m_rd           in   REG_ADDR_W  destination register
//   m_alu_result   in   DATA_W      ALU result / memory address in MEM
//   mem_read_data  in   DATA_W      memory_stage read_data, valid the cycle after capture
//   rs1_addr       in   REG_ADDR_W  read port 1 address (decode)
//   rs2_addr       in   REG_ADDR_W  read port 2 address (decode)
//   rs1_data       out  DATA_W      read port 1 data, combinational
//   rs2_data       out  DATA_W      read port 2 data, combinational
//   wb_valid       out  1           MEM/WB register holds a live instruction
//   wb_we          out  1           register-file write happens at the next edge
//   wb_rd          out  REG_ADDR_W  write destination
//   wb_data        out  DATA_W      write value
//   fwd_valid      out  1           forwarding bus valid (to the EX forward mux)
//   fwd_rd         out  REG_ADDR_W  forwarding register index
//   fwd_data       out  DATA_W      forwarding value
//   retired_count  out  CNT_W       number of committed valid instructions, saturating
// BEHAVIOUR
//   Reset (async)
//   - MEM/WB valid=0; all MEM/WB fields=0; all registers=0; retired_count=0.
//   - Hence wb_valid=wb_we=fwd_valid=0; wb_rd=fwd_rd=0; wb_data=fwd_data=0.
//   - Reset mid-operation discards the in-flight instruction with no register write.
//   Capture (posedge; W = MEM/WB register)
//   - flush=1: W.valid<=0, other fields don't-care. flush beats stall.
//   - else stall=1: W holds all fields.
//   - else: W <= {m_valid, m_reg_write, m_mem_to_reg, m_rd, m_alu_result}.
//   Alignment
//   - memory_stage registers read_data on the same edge that W captures.
//   - So mem_read_data belongs to W in the following cycle: one-cycle load latency.
//   - Upstream holds MemRead and the address during stall, so mem_read_data stays
//     consistent while W is held.
//   Writeback select (combinational)
//   - wb_data = W.mem_to_reg ? mem_read_data : W.alu_result.
//   - wb_rd   = W.rd.
//   - wb_valid = W.valid.
//   - wb_we   = W.valid & W.reg_write & (W.rd!=0) & ~stall.
//   Commit (posedge)
//   - If wb_we: reg[wb_rd] <= wb_data.
//   - r0 is hard-wired zero: writes are ignored and reads return 0.
//   - A stalled instruction commits exactly once, on the first edge with stall=0.
//   Read ports
//   - rsN_data = (rsN_addr==0)                 ? 0
//              : (wb_we & rsN_addr==wb_rd)     ? wb_data
//              :                                 reg[rsN_addr].
//   - This is write-through bypass: the same-cycle writer is visible.
//   Forwarding bus
//   - fwd_valid = W.valid & W.reg_write & (W.rd!=0). Not gated by stall.
//   - fwd_rd = W.rd; fwd_data = wb_data.
//   Counter
//   - At each edge with W.valid & ~stall, retired_count increments.
//   - Counts every committed instruction, including ones with reg_write=0 (stores).
//   - Saturates at 2**CNT_W-1, no wrap.
//   Simultaneous flush and commit
//   - Commit uses the current W.
//   - flush only affects the value being captured.
//   - The committing instruction completes normally.
// TESTING
//   1. ALU op: m_valid=1, reg_write=1, mem_to_reg=0, rd=3, alu=8'h5A -> next cycle wb_we=1, wb_data=5A; after edge rs1_addr=3 reads 5A; retired_count=1.
//   2. Load: rd=2, mem_to_reg=1, memory returns 8'hC3 -> wb_data=C3 exactly one cycle after capture; reg2=C3.
//   3. Bypass: rd=5, wb_data=8'h11 while rs2_addr=5 and reg5=0 -> rs2_data=11 in the same cycle.
//   4. r0: write rd=0 with value 8'hFF -> wb_we=0, fwd_valid=0; rs1_addr=0 reads 00; retired_count still increments.
//   5. Stall 3 cycles, then release, with W holding rd=4, value 8'h77 -> wb_we=0 during the stall, fwd_valid=1 throughout; exactly one write; count +1.
//   6. Asserting flush during capture drops the instruction (no write, no count); async reset mid-stream -> all outputs 0, registers 0, count 0.

Source files
------------

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, load-data alignment, writeback select,
// 2-read-port register file with write-through bypass, forwarding bus and retire counter.
module writeback_stage #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  m_valid,
  input  logic                  m_reg_write,
  input  logic                  m_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] m_rd,
  input  logic [DATA_W-1:0]     m_alu_result,
  input  logic [DATA_W-1:0]     mem_read_data,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0]     rs1_data,
  output logic [DATA_W-1:0]     rs2_data,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [CNT_W-1:0]      retired_count
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;

  logic                  w_valid_reg;
  logic                  w_reg_write_reg;
  logic                  w_mem_to_reg_reg;
  logic [REG_ADDR_W-1:0] w_rd_reg;
  logic [DATA_W-1:0]     w_alu_reg;

  logic [DATA_W-1:0]     rf_reg [NUM_REGS];
  logic [CNT_W-1:0]      cnt_reg;

  logic                  writes_rd;
  logic [REG_ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0]     rd_data [2];

  // MEM/WB pipeline register; flush only clears valid, the payload is don't-care
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_valid_reg      <= 1'b0;
      w_reg_write_reg  <= 1'b0;
      w_mem_to_reg_reg <= 1'b0;
      w_rd_reg         <= '0;
      w_alu_reg        <= '0;
    end else if (flush) begin
      w_valid_reg      <= 1'b0;
    end else if (!stall) begin
      w_valid_reg      <= m_valid;
      w_reg_write_reg  <= m_reg_write;
      w_mem_to_reg_reg <= m_mem_to_reg;
      w_rd_reg         <= m_rd;
      w_alu_reg        <= m_alu_result;
    end
  end

  // Load data arrives one cycle after capture, so it lines up with W here
  assign wb_data   = w_mem_to_reg_reg ? mem_read_data : w_alu_reg;
  assign wb_rd     = w_rd_reg;
  assign wb_valid  = w_valid_reg;
  assign writes_rd = w_valid_reg & w_reg_write_reg & (w_rd_reg != '0);
  assign wb_we     = writes_rd & ~stall;

  assign fwd_valid = writes_rd;
  assign fwd_rd    = w_rd_reg;
  assign fwd_data  = wb_data;

  // r0 is never written (wb_we excludes rd==0) so it stays at its reset value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_reg[i] <= '0;
      end
    end else if (wb_we) begin
      rf_reg[wb_rd] <= wb_data;
    end
  end

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
      assign rd_data[gi] = (rd_addr[gi] == '0)                ? '0
                         : (wb_we && (rd_addr[gi] == wb_rd)) ? wb_data
                         :                                     rf_reg[rd_addr[gi]];
    end
  endgenerate

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];

  // Retire counter includes non-writing instructions such as stores
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (w_valid_reg && !stall && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign retired_count = cnt_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus pushes expected commits,
// a monitor pops and compares on every register-file write.
module tb_writeback_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       m_valid = 1'b0;
  logic       m_reg_write = 1'b0;
  logic       m_mem_to_reg = 1'b0;
  logic [2:0] m_rd = '0;
  logic [7:0] m_alu_result = '0;
  logic [7:0] mem_read_data = '0;
  logic [2:0] rs1_addr = '0;
  logic [2:0] rs2_addr = '0;
  logic [7:0] rs1_data, rs2_data, wb_data, fwd_data;
  logic       wb_valid, wb_we, fwd_valid;
  logic [2:0] wb_rd, fwd_rd;
  logic [15:0] retired_count;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  writeback_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_reg_write(m_reg_write), .m_mem_to_reg(m_mem_to_reg),
    .m_rd(m_rd), .m_alu_result(m_alu_result), .mem_read_data(mem_read_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Present one instruction to MEM for a single capture edge
  task automatic issue(input logic rw, input logic m2r, input logic [2:0] rd,
                       input logic [7:0] alu, input logic fl);
    m_valid = 1'b1; m_reg_write = rw; m_mem_to_reg = m2r; m_rd = rd;
    m_alu_result = alu; flush = fl;
    @(posedge clk); #1;
    m_valid = 1'b0; m_reg_write = 1'b0; m_mem_to_reg = 1'b0; flush = 1'b0;
  endtask

  task automatic push(input logic [2:0] rd, input logic [7:0] data);
    exp_t e;
    e.rd = rd; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic next_edge();
    @(posedge clk); #1;
  endtask

  // Monitor: every register-file write must match the oldest expected commit
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_we) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", wb_rd, wb_data);
        end else begin
          e = exp_q.pop_front();
          $display("commit rd=%0d data=%h (expected rd=%0d data=%h)", wb_rd, wb_data, e.rd, e.data);
          check("commit_rd", 32'(wb_rd), 32'(e.rd));
          check("commit_data", 32'(wb_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_wb_we", 32'(wb_we), 0);
    check("rst_fwd_valid", 32'(fwd_valid), 0);
    check("rst_wb_data", 32'(wb_data), 0);
    check("rst_count", 32'(retired_count), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    next_edge();

    // 1: ALU op
    push(3'd3, 8'h5A);
    issue(1'b1, 1'b0, 3'd3, 8'h5A, 1'b0);
    @(negedge clk);
    check("t1_wb_we", 32'(wb_we), 1);
    check("t1_wb_data", 32'(wb_data), 32'h5A);
    check("t1_fwd_valid", 32'(fwd_valid), 1);
    check("t1_fwd_rd", 32'(fwd_rd), 3);
    check("t1_fwd_data", 32'(fwd_data), 32'h5A);
    check("t1_count_pre", 32'(retired_count), 0);
    next_edge();
    rs1_addr = 3'd3; #1;
    check("t1_rs1", 32'(rs1_data), 32'h5A);
    check("t1_count", 32'(retired_count), 1);

    // 2: load, data returned by memory one cycle after capture
    push(3'd2, 8'hC3);
    issue(1'b1, 1'b1, 3'd2, 8'h40, 1'b0);
    mem_read_data = 8'hC3;
    @(negedge clk);
    check("t2_wb_data", 32'(wb_data), 32'hC3);
    next_edge();
    rs1_addr = 3'd2; #1;
    check("t2_rs1", 32'(rs1_data), 32'hC3);
    check("t2_count", 32'(retired_count), 2);

    // 3: same-cycle bypass
    push(3'd5, 8'h11);
    issue(1'b1, 1'b0, 3'd5, 8'h11, 1'b0);
    rs2_addr = 3'd5; #1;
    check("t3_bypass", 32'(rs2_data), 32'h11);
    next_edge();
    check("t3_rs2_after", 32'(rs2_data), 32'h11);
    check("t3_count", 32'(retired_count), 3);

    // 4: write to r0 is dropped but still retires
    issue(1'b1, 1'b0, 3'd0, 8'hFF, 1'b0);
    rs1_addr = 3'd0;
    @(negedge clk);
    check("t4_wb_valid", 32'(wb_valid), 1);
    check("t4_wb_we", 32'(wb_we), 0);
    check("t4_fwd_valid", 32'(fwd_valid), 0);
    check("t4_rs1_r0", 32'(rs1_data), 0);
    next_edge();
    check("t4_count", 32'(retired_count), 4);

    // 5: three-cycle stall, exactly one commit on release
    push(3'd4, 8'h77);
    issue(1'b1, 1'b0, 3'd4, 8'h77, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_stall_we", 32'(wb_we), 0);
      check("t5_stall_fwd", 32'(fwd_valid), 1);
      check("t5_stall_fwd_data", 32'(fwd_data), 32'h77);
      next_edge();
    end
    check("t5_count_held", 32'(retired_count), 4);
    stall = 1'b0;
    @(negedge clk);
    check("t5_release_we", 32'(wb_we), 1);
    next_edge();
    rs1_addr = 3'd4; #1;
    check("t5_rs1", 32'(rs1_data), 32'h77);
    check("t5_count", 32'(retired_count), 5);

    // Back-to-back ALU ops
    push(3'd6, 8'hA1);
    push(3'd7, 8'hB2);
    issue(1'b1, 1'b0, 3'd6, 8'hA1, 1'b0);
    issue(1'b1, 1'b0, 3'd7, 8'hB2, 1'b0);
    next_edge();
    rs1_addr = 3'd6; rs2_addr = 3'd7; #1;
    check("b2b_rs1", 32'(rs1_data), 32'hA1);
    check("b2b_rs2", 32'(rs2_data), 32'hB2);
    check("b2b_count", 32'(retired_count), 7);

    // 6a: flush during capture drops the instruction
    issue(1'b1, 1'b0, 3'd1, 8'h99, 1'b1);
    @(negedge clk);
    check("t6_flush_valid", 32'(wb_valid), 0);
    check("t6_flush_we", 32'(wb_we), 0);
    next_edge();
    rs1_addr = 3'd1; #1;
    check("t6_flush_rs1", 32'(rs1_data), 0);
    check("t6_flush_count", 32'(retired_count), 7);

    // Flush while an older instruction commits: the older one completes
    push(3'd6, 8'hC4);
    issue(1'b1, 1'b0, 3'd6, 8'hC4, 1'b0);
    issue(1'b1, 1'b0, 3'd1, 8'hEE, 1'b1);
    check("fc_valid", 32'(wb_valid), 0);
    rs1_addr = 3'd6; rs2_addr = 3'd1; #1;
    check("fc_rs1", 32'(rs1_data), 32'hC4);
    check("fc_rs2", 32'(rs2_data), 0);
    check("fc_count", 32'(retired_count), 8);

    // 6b: async reset mid-stream discards the in-flight instruction
    issue(1'b1, 1'b0, 3'd3, 8'hDD, 1'b0);
    reset = 1'b1; #1;
    check("rst2_wb_valid", 32'(wb_valid), 0);
    check("rst2_wb_we", 32'(wb_we), 0);
    check("rst2_wb_data", 32'(wb_data), 0);
    check("rst2_fwd_rd", 32'(fwd_rd), 0);
    rs1_addr = 3'd3; rs2_addr = 3'd5; #1;
    check("rst2_rs1", 32'(rs1_data), 0);
    check("rst2_rs2", 32'(rs2_data), 0);
    check("rst2_count", 32'(retired_count), 0);
    @(negedge clk);
    reset = 1'b0;
    next_edge();

    // Recovery after reset
    push(3'd3, 8'h3C);
    issue(1'b1, 1'b0, 3'd3, 8'h3C, 1'b0);
    next_edge();
    #1;
    check("rec_rs1", 32'(rs1_data), 32'h3C);
    check("rec_count", 32'(retired_count), 1);

    next_edge();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
